// File: rtl/fir_capture_buffer_pkg.sv
// rtl/fir_capture_buffer_pkg.sv - shared types and defaults for the FIR capture buffer
package fir_capture_buffer_pkg;

    localparam int N_DEF     = 16;
    localparam int DEPTH_DEF = 128;
    localparam int SKIP_DEF  = 0;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int AW_DEF = addr_width(DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/fir_capture_buffer_if.sv
// rtl/fir_capture_buffer_if.sv - sample stream and readout bus of the FIR capture buffer
interface fir_capture_buffer_if
    import fir_capture_buffer_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) ();

    logic          sample_valid;
    logic [N-1:0]  sample_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          rd_valid;

    modport master (
        output sample_valid,
        output sample_in,
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  sample_valid,
        input  sample_in,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );

endinterface

// File: rtl/fir_capture_ram.sv
// rtl/fir_capture_ram.sv - sample store: one write port, one registered read port
module fir_capture_ram
    import fir_capture_buffer_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];
    logic [N-1:0] rdata_q;
    logic [N-1:0] rdata_d;

    // Storage is deliberately unreset so a capture survives a reset of the control logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fir_capture_buffer.sv
// rtl/fir_capture_buffer.sv - arm-triggered capture of filter output samples with peak tracking
module fir_capture_buffer
    import fir_capture_buffer_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int SKIP  = SKIP_DEF,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    fir_capture_buffer_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          count,
    output logic [N-1:0]         peak_max,
    output logic [N-1:0]         peak_min
);

    localparam int            SW       = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [SW:0]   SKIP_V   = (SW + 1)'(SKIP);
    localparam logic [AW:0]   LAST_CNT = (AW + 1)'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] skip_q, skip_d;
    logic [SW:0]   skip_inc;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [N-1:0]  peak_max_q, peak_max_d;
    logic [N-1:0]  peak_min_q, peak_min_d;
    logic          rd_valid_q, rd_valid_d;
    logic          mem_we;
    logic          mem_re;

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        peak_max_d = peak_max_q;
        peak_min_d = peak_min_q;
        mem_we     = 1'b0;
        skip_inc   = {1'b0, skip_q} + (SW + 1)'(1);

        // A read issued together with arm in DONE still sees the finished capture.
        mem_re     = bus.rd_en && (state_q == ST_DONE);
        rd_valid_d = mem_re;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d  = ST_ARMED;
                    skip_d   = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end
            end
            ST_ARMED: begin
                if (SKIP == 0) begin
                    state_d = ST_CAPTURE;
                end else if (bus.sample_valid) begin
                    skip_d = skip_inc[SW-1:0];
                    if (skip_inc == SKIP_V) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (bus.sample_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + (AW + 1)'(1);
                    if (count_q == '0) begin
                        peak_max_d = bus.sample_in;
                        peak_min_d = bus.sample_in;
                    end else begin
                        if ($signed(bus.sample_in) > $signed(peak_max_q)) begin
                            peak_max_d = bus.sample_in;
                        end
                        if ($signed(bus.sample_in) < $signed(peak_min_q)) begin
                            peak_min_d = bus.sample_in;
                        end
                    end
                    if (count_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            peak_max_q <= '0;
            peak_min_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            peak_max_q <= peak_max_d;
            peak_min_q <= peak_min_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    fir_capture_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (bus.sample_in),
        .re    (mem_re),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid = rd_valid_q;
    assign busy         = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);
    assign count        = count_q;
    assign peak_max     = peak_max_q;
    assign peak_min     = peak_min_q;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// tb/tb_fir_capture_buffer.sv - scoreboard bench for fir_capture_buffer (SKIP=0 and SKIP=3 instances)
module tb_fir_capture_buffer;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        arm_a = 1'b0;
    logic        arm_b = 1'b0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [7:0]  count_a;
    logic [3:0]  count_b;
    logic [15:0] pmax_a, pmin_a, pmax_b, pmin_b;

    fir_capture_buffer_if #(.N(16), .AW(7)) ba ();
    fir_capture_buffer_if #(.N(16), .AW(3)) bb ();

    fir_capture_buffer #(.N(16), .DEPTH(128), .SKIP(0)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm_a),
        .bus      (ba),
        .busy     (busy_a),
        .done     (done_a),
        .count    (count_a),
        .peak_max (pmax_a),
        .peak_min (pmin_a)
    );

    fir_capture_buffer #(.N(16), .DEPTH(8), .SKIP(3)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm_b),
        .bus      (bb),
        .busy     (busy_b),
        .done     (done_b),
        .count    (count_b),
        .peak_max (pmax_b),
        .peak_min (pmin_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input int addr, input logic [15:0] exp);
        ba.rd_en   = 1'b1;
        ba.rd_addr = 7'(addr);
        qa.push_back('{d: exp, c: cyc + 1});
        tick();
    endtask

    task automatic read_b(input int addr, input logic [15:0] exp);
        bb.rd_en   = 1'b1;
        bb.rd_addr = 3'(addr);
        qb.push_back('{d: exp, c: cyc + 1});
        tick();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (qa.size() > 0 && qa[0].c < cyc) begin
                ea = qa.pop_front();
                checks++;
                errors++;
                $display("FAIL rd_a_missing: got no rd_valid at cycle %0d, required data %0h", ea.c, ea.d);
            end
            if (ba.rd_valid) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL rd_a_unexpected: got rd_valid=1 data=%0h, required rd_valid=0", ba.rd_data);
                end else begin
                    ea = qa.pop_front();
                    if (ba.rd_data !== ea.d || cyc != ea.c) begin
                        errors++;
                        $display("FAIL rd_a: got data=%0h cycle=%0d, required data=%0h cycle=%0d",
                                 ba.rd_data, cyc, ea.d, ea.c);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            while (qb.size() > 0 && qb[0].c < cyc) begin
                eb = qb.pop_front();
                checks++;
                errors++;
                $display("FAIL rd_b_missing: got no rd_valid at cycle %0d, required data %0h", eb.c, eb.d);
            end
            if (bb.rd_valid) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL rd_b_unexpected: got rd_valid=1 data=%0h, required rd_valid=0", bb.rd_data);
                end else begin
                    eb = qb.pop_front();
                    if (bb.rd_data !== eb.d || cyc != eb.c) begin
                        errors++;
                        $display("FAIL rd_b: got data=%0h cycle=%0d, required data=%0h cycle=%0d",
                                 bb.rd_data, cyc, eb.d, eb.c);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"},     32'(busy_a),      32'd0);
        chk({tag, "_done"},     32'(done_a),      32'd0);
        chk({tag, "_count"},    32'(count_a),     32'd0);
        chk({tag, "_rd_valid"}, 32'(ba.rd_valid), 32'd0);
        chk({tag, "_rd_data"},  32'(ba.rd_data),  32'd0);
        chk({tag, "_pmax"},     32'(pmax_a),      32'd0);
        chk({tag, "_pmin"},     32'(pmin_a),      32'd0);
    endtask

    initial begin
        logic [15:0] v;
        ba.sample_valid = 1'b0; ba.sample_in = '0; ba.rd_en = 1'b0; ba.rd_addr = '0;
        bb.sample_valid = 1'b0; bb.sample_in = '0; bb.rd_en = 1'b0; bb.rd_addr = '0;
        #2;
        chk_reset_a("rst");
        tick(); tick();
        reset = 1'b1;
        tick();

        // No capture without arm; read outside DONE returns nothing.
        ba.sample_valid = 1'b1; ba.sample_in = 16'h0055;
        tick(); tick();
        ba.sample_valid = 1'b0;
        chk("idle_count", 32'(count_a), 32'd0);
        chk("idle_busy",  32'(busy_a),  32'd0);
        ba.rd_en = 1'b1; ba.rd_addr = 7'd5;
        tick();
        ba.rd_en = 1'b0;
        chk("idle_rd_valid", 32'(ba.rd_valid), 32'd0);
        chk("idle_rd_data",  32'(ba.rd_data),  32'd0);

        // Ramp 0..127
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        chk("armed_busy", 32'(busy_a), 32'd1);
        tick();
        for (int i = 0; i < 128; i++) begin
            ba.sample_valid = 1'b1; ba.sample_in = 16'(i);
            tick();
            if (i == 126) chk("ramp_done_early", 32'(done_a), 32'd0);
        end
        ba.sample_valid = 1'b0;
        chk("ramp_done",  32'(done_a),  32'd1);
        chk("ramp_busy",  32'(busy_a),  32'd0);
        chk("ramp_count", 32'(count_a), 32'd128);
        chk("ramp_pmax",  32'(pmax_a),  32'd127);
        chk("ramp_pmin",  32'(pmin_a),  32'd0);
        ba.sample_valid = 1'b1; ba.sample_in = 16'h7777;
        tick();
        ba.sample_valid = 1'b0;
        chk("ramp_count_sat", 32'(count_a), 32'd128);
        for (int a = 0; a < 128; a++) read_a(a, 16'(a));
        ba.rd_en = 1'b0;
        tick(); tick();

        // Signed peaks; read while ARMED must not update rd_data
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        chk("rearm_pmax_persist", 32'(pmax_a), 32'd127);
        ba.rd_en = 1'b1; ba.rd_addr = 7'd5;
        tick();
        ba.rd_en = 1'b0;
        chk("armed_rd_valid", 32'(ba.rd_valid), 32'd0);
        chk("armed_rd_data",  32'(ba.rd_data),  32'd127);
        for (int i = 0; i < 128; i++) begin
            case (i)
                0:       v = 16'hFED4;
                1:       v = 16'd500;
                2:       v = 16'h8000;
                3:       v = 16'h7FFF;
                default: v = 16'h0000;
            endcase
            ba.sample_valid = 1'b1; ba.sample_in = v;
            tick();
            if (i == 0) begin
                chk("first_pmax", 32'(pmax_a), 32'h0000FED4);
                chk("first_pmin", 32'(pmin_a), 32'h0000FED4);
            end
        end
        ba.sample_valid = 1'b0;
        chk("signed_done", 32'(done_a), 32'd1);
        chk("signed_pmax", 32'(pmax_a), 32'h00007FFF);
        chk("signed_pmin", 32'(pmin_a), 32'h00008000);
        read_a(2, 16'h8000);
        read_a(0, 16'hFED4);
        ba.rd_en = 1'b0;
        tick();

        // Valid on every other cycle, stray arm mid-capture
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        tick();
        for (int k = 0; k < 256; k++) begin
            ba.sample_valid = (k % 2 == 0);
            ba.sample_in    = 16'(1000 + k / 2);
            arm_a           = (k == 51);
            tick();
            if (k == 10)  chk("toggle_count_k10", 32'(count_a), 32'd6);
            if (k == 11)  chk("toggle_count_k11", 32'(count_a), 32'd6);
            if (k == 51)  chk("mid_arm_count",    32'(count_a), 32'd26);
            if (k == 253) chk("toggle_done_early", 32'(done_a), 32'd0);
        end
        arm_a = 1'b0;
        ba.sample_valid = 1'b0;
        chk("toggle_done",  32'(done_a),  32'd1);
        chk("toggle_count", 32'(count_a), 32'd128);
        read_a(0,   16'd1000);
        read_a(64,  16'd1064);
        read_a(127, 16'd1127);

        // Arm together with a read in DONE
        ba.rd_en = 1'b1; ba.rd_addr = 7'd3; arm_a = 1'b1;
        qa.push_back('{d: 16'd1003, c: cyc + 1});
        tick();
        arm_a = 1'b0; ba.rd_en = 1'b0;
        chk("arm_rd_busy",  32'(busy_a),      32'd1);
        chk("arm_rd_valid", 32'(ba.rd_valid), 32'd1);
        tick();
        for (int i = 0; i < 40; i++) begin
            ba.sample_valid = 1'b1; ba.sample_in = 16'(2000 + i);
            tick();
        end
        ba.sample_valid = 1'b0;
        chk("partial_count", 32'(count_a), 32'd40);

        // Asynchronous reset mid-capture
        #2;
        reset = 1'b0;
        #1;
        chk_reset_a("async_rst");
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        tick();
        for (int i = 0; i < 128; i++) begin
            ba.sample_valid = 1'b1; ba.sample_in = 16'(i * 256 - 16000);
            tick();
        end
        ba.sample_valid = 1'b0;
        chk("recap_done",  32'(done_a),  32'd1);
        chk("recap_count", 32'(count_a), 32'd128);
        chk("recap_pmax",  32'(pmax_a),  32'h00004080);
        chk("recap_pmin",  32'(pmin_a),  32'h0000C180);
        read_a(0,   16'hC180);
        read_a(40,  16'hE980);
        read_a(127, 16'h4080);
        ba.rd_en = 1'b0;
        tick();

        // SKIP=3 instance: 10,11,12 discarded
        arm_b = 1'b1; tick(); arm_b = 1'b0;
        chk("b_armed_busy", 32'(busy_b), 32'd1);
        for (int i = 0; i < 11; i++) begin
            bb.sample_valid = 1'b1; bb.sample_in = 16'(10 + i);
            tick();
            if (i == 2) begin
                chk("b_skip_count", 32'(count_b), 32'd0);
                chk("b_skip_busy",  32'(busy_b),  32'd1);
            end
            if (i == 9) chk("b_done_early", 32'(done_b), 32'd0);
        end
        bb.sample_valid = 1'b0;
        chk("b_done",  32'(done_b),  32'd1);
        chk("b_count", 32'(count_b), 32'd8);
        chk("b_pmax",  32'(pmax_b),  32'd20);
        chk("b_pmin",  32'(pmin_b),  32'd13);
        for (int a = 0; a < 8; a++) read_b(a, 16'(13 + a));
        bb.rd_en = 1'b0;
        tick(); tick();

        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_capture_buffer.md
FIR_CAPTURE_BUFFER -- requirements
Module: fir_capture_buffer

Interface
REQ-001 Parameter N, default 16, sample width in bits; samples are two's-complement signed.
REQ-002 Parameter DEPTH, default 128, number of samples stored per capture.
REQ-003 Parameter SKIP, default 0, number of leading valid samples discarded after arming.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port arm  input  1  one-cycle request to start a new capture.
REQ-007 Port sample_valid  input  1  sample_in qualifier.
REQ-008 Port sample_in  input  N  filter output sample.
REQ-009 Port rd_en  input  1  readout request.
REQ-010 Port rd_addr  input  log2(DEPTH)  readout sample index.
REQ-011 Port rd_data  output  N  registered readout data.
REQ-012 Port rd_valid  output  1  rd_data qualifier.
REQ-013 Port busy  output  1  high in ARMED or CAPTURE.
REQ-014 Port done  output  1  high in DONE.
REQ-015 Port count  output  log2(DEPTH)+1  samples stored in the current capture.
REQ-016 Port peak_max, peak_min  output  N each  signed extremes of the stored samples.

Function
REQ-017 FSM states: IDLE, ARMED, CAPTURE, DONE; busy and done are decoded from state only.
REQ-018 IDLE or DONE with arm=1 -> ARMED; skip counter, count, and write pointer cleared to 0.
REQ-019 ARMED: each sample_valid increments the skip counter without storing; on reaching SKIP -> CAPTURE; SKIP=0 -> CAPTURE on the cycle after arm.
REQ-020 CAPTURE: each sample_valid writes sample_in to mem[wr_ptr], then increments wr_ptr and count.
REQ-021 The write that makes count equal DEPTH moves the FSM to DONE in the same edge; count saturates at DEPTH; no wrap or overwrite.
REQ-022 sample_valid=0 cycles stall capture indefinitely; no timeout.
REQ-023 arm in ARMED or CAPTURE is ignored.
REQ-024 The first stored sample loads both peak_max and peak_min; each later stored sample updates them by signed compare.
REQ-025 Readout is legal only in DONE: rd_en=1 -> rd_data=mem[rd_addr] and rd_valid=1 on the next edge; latency is 1 cycle.
REQ-026 Back-to-back rd_en is supported at one sample per cycle.
REQ-027 rd_en outside DONE -> rd_valid=0 next cycle and rd_data holds its previous value.
REQ-028 arm and rd_en together in DONE: the read completes with DONE-state data, and the FSM enters ARMED.
REQ-029 Peak values and memory contents persist in DONE until the next stored sample after re-arm.

Reset
REQ-030 reset low, asynchronously: state=IDLE, count=0, wr_ptr=0, skip counter=0, rd_valid=0, rd_data=0, peak_max=0, peak_min=0.
REQ-031 Reset during ARMED or CAPTURE abandons the capture; memory array contents are not cleared.
REQ-032 After reset deasserts, no capture begins until arm.

Structure
REQ-033 A shared package holds the FSM state enum, default N, DEPTH and SKIP, and the address width derived as log2(DEPTH).
REQ-034 One sub-module, fir_capture_ram: single-port write, registered-read dual-port array, with no reset on storage.

Verification
REQ-035 Reset, arm, then 128 consecutive valid samples 0..127 -> done rises after the 128th sample; count=128; reading addresses 0..127 back-to-back returns 0..127, each one cycle after its rd_en.
REQ-036 SKIP=3, arm, then samples 10,11,12,13,... -> mem[0]=13; 10..12 are discarded.
REQ-037 Signed samples -300, 500, -32768, 32767, then zeros -> peak_min=-32768 (0x8000) and peak_max=32767.
REQ-038 sample_valid toggling every other cycle during capture -> exactly DEPTH stores; count increments only on valid cycles; arm pulsed mid-capture has no effect.
REQ-039 reset low after 40 stored samples -> all outputs return to REQ-030 values immediately; re-arm and a full capture complete normally.
REQ-040 rd_en with rd_addr=5 in IDLE -> rd_valid=0 and rd_data unchanged; arm and rd_en together in DONE -> valid read data returned and busy=1 the next cycle.
